shift_seq_ctrl: RTL

Sequencer that drives a WIDTH-bit right shift register (ports load, d, shift_en, q) as a parallel-to-serial transmitter. It accepts a word over a valid/ready handshake and loads it into the register. It then issues exactly WIDTH shift pulses, spaced by a programmable bit period, and presents the register LSB as the serial bit. It sits between a word producer and the shift register datapath, and also provides abort and completion signalling.

---
 rtl/shift_seq_ctrl.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/shift_seq_ctrl.sv
// shift_seq_ctrl: parallel-to-serial sequencer for an external WIDTH-bit right
// shift register. Accepts a word on a valid/ready handshake, loads it into the
// register, then issues WIDTH shift pulses spaced div+1 clocks apart while the
// register LSB is presented as the serial bit.
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready   word handshake; in_data is the word, LSB sent first
//   div                 bit period minus one, sampled at accept
//   abort               synchronous frame abort (ignored in IDLE)
//   sr_load/sr_d        parallel load of the shift register
//   sr_shift_en         one-cycle shift strobe
//   sr_q                shift register contents (only bit 0 is observed)
//   ser_bit/ser_valid   serial data and its qualifier
//   busy                frame in progress (LOAD, SHIFT, DONE)
//   done                one-cycle pulse on successful frame completion
module shift_seq_ctrl #(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned DIV_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             in_ready,
   input  logic [DIV_W-1:0] div,
   input  logic             abort,
   output logic             sr_load,
   output logic [WIDTH-1:0] sr_d,
   output logic             sr_shift_en,
   input  logic [WIDTH-1:0] sr_q,
   output logic             ser_bit,
   output logic             ser_valid,
   output logic             busy,
   output logic             done
);

   localparam int unsigned CNT_W = $clog2(WIDTH + 1);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_LOAD  = 2'd1;
   localparam logic [1:0] ST_SHIFT = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   logic [1:0]       state,   state_nxt;
   logic [WIDTH-1:0] data_q,  data_nxt;
   logic [DIV_W-1:0] per_q,   per_nxt;
   logic [DIV_W-1:0] div_cnt, div_cnt_nxt;
   logic [CNT_W-1:0] bit_cnt, bit_cnt_nxt;

   logic             in_ready_nxt;
   logic             sr_load_nxt;
   logic [WIDTH-1:0] sr_d_nxt;
   logic             sr_shift_en_nxt;
   logic             ser_valid_nxt;
   logic             busy_nxt;
   logic             done_nxt;

   // Upper register bits belong to the datapath; only the LSB is serialised.
   logic unused_sr_q;
   assign unused_sr_q = ^sr_q[WIDTH-1:1];

   // State, counters and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= ST_IDLE;
         data_q      <= '0;
         per_q       <= '0;
         div_cnt     <= '0;
         bit_cnt     <= '0;
         in_ready    <= 1'b1;
         sr_load     <= 1'b0;
         sr_d        <= '0;
         sr_shift_en <= 1'b0;
         ser_valid   <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
      end else begin
         state       <= state_nxt;
         data_q      <= data_nxt;
         per_q       <= per_nxt;
         div_cnt     <= div_cnt_nxt;
         bit_cnt     <= bit_cnt_nxt;
         in_ready    <= in_ready_nxt;
         sr_load     <= sr_load_nxt;
         sr_d        <= sr_d_nxt;
         sr_shift_en <= sr_shift_en_nxt;
         ser_valid   <= ser_valid_nxt;
         busy        <= busy_nxt;
         done        <= done_nxt;
      end
   end

   // Next-state and counter logic; outputs are decoded from the next state so
   // the registered outputs line up with the state they describe.
   always_comb begin
      state_nxt   = state;
      data_nxt    = data_q;
      per_nxt     = per_q;
      div_cnt_nxt = div_cnt;
      bit_cnt_nxt = bit_cnt;

      case (state)
         ST_IDLE: begin
            // in_ready is always high in IDLE, so in_valid alone is an accept.
            if (in_valid) begin
               data_nxt  = in_data;
               per_nxt   = div;
               state_nxt = ST_LOAD;
            end
         end
         ST_LOAD: begin
            div_cnt_nxt = per_q;
            bit_cnt_nxt = '0;
            state_nxt   = abort ? ST_IDLE : ST_SHIFT;
         end
         ST_SHIFT: begin
            if (div_cnt == '0) begin
               // Shift pulse is issued this cycle (sr_shift_en already high).
               bit_cnt_nxt = bit_cnt + CNT_W'(1);
               div_cnt_nxt = per_q;
               if (bit_cnt == CNT_W'(WIDTH - 1)) begin
                  state_nxt = ST_DONE;
               end
            end else begin
               div_cnt_nxt = div_cnt - DIV_W'(1);
            end
            // Abort takes priority over completion.
            if (abort) begin
               state_nxt = ST_IDLE;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase

      in_ready_nxt    = (state_nxt == ST_IDLE);
      sr_load_nxt     = (state_nxt == ST_LOAD);
      sr_d_nxt        = (state_nxt == ST_LOAD) ? data_nxt : '0;
      sr_shift_en_nxt = (state_nxt == ST_SHIFT) && (div_cnt_nxt == '0);
      ser_valid_nxt   = (state_nxt == ST_SHIFT);
      busy_nxt        = (state_nxt != ST_IDLE);
      done_nxt        = (state_nxt == ST_DONE);
   end

   // The register LSB is qualified by the registered ser_valid flag.
   assign ser_bit = ser_valid & sr_q[0];

endmodule
